imm_encode: RTL and testbench

Immediate/instruction encoder for the RV32I datapath, the inverse of the sign-extend unit: it takes decoded fields (opcode, registers, funct bits, 32-bit immediate, format type) and packs them into a 32-bit instruction word. It checks that the immediate fits the format and flags violations. It sits between the test/program generator and instruction memory load, behind a valid/ready handshake with a two-entry skid buffer. It also keeps saturating counters of emitted words and range errors.

---
 rtl/imm_encode_pkg.sv | 39 +++
 rtl/imm_encode_instr_pack.sv | 54 +++++
 rtl/imm_encode.sv | 118 +++++++++++
 tb/tb_imm_encode.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_encode_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Holds the format select, the base opcodes and the output buffer states.
package imm_pkg;

   typedef enum logic [2:0] {
      I_TYPE = 3'b000,
      S_TYPE = 3'b001,
      B_TYPE = 3'b010,
      J_TYPE = 3'b011,
      U_TYPE = 3'b100,
      R_TYPE = 3'b101
   } imm_type_t;

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] OP     = 7'b0110011;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } buf_state_t;

   // True when bits 31 down to lo all match the sign bit.
   function automatic logic sext_fits(input logic [31:0] v, input int unsigned lo);
      logic ok;
      ok = 1'b1;
      for (int unsigned i = lo; i < 31; i++) begin
         if (v[i] != v[31]) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/imm_encode_instr_pack.sv
// Combinational field packing and immediate range check.
// Reserved format codes yield a zero word flagged as an error.
module instr_pack
   import imm_pkg::*;
#(
   parameter int unsigned IMM_TYPE_W = 3
) (
   input  logic [IMM_TYPE_W-1:0] imm_type,
   input  logic [6:0]            opcode,
   input  logic [4:0]            rd,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   input  logic [31:0]           imm,
   output logic [31:0]           instr,
   output logic                  err
);

   always_comb begin
      instr = '0;
      err   = 1'b0;
      case (imm_type)
         IMM_TYPE_W'(I_TYPE): begin
            instr = {imm[11:0], rs1, funct3, rd, opcode};
            err   = !sext_fits(imm, 11);
         end
         IMM_TYPE_W'(S_TYPE): begin
            instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            err   = !sext_fits(imm, 11);
         end
         IMM_TYPE_W'(B_TYPE): begin
            instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            err   = !sext_fits(imm, 12) || imm[0];
         end
         IMM_TYPE_W'(J_TYPE): begin
            instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            err   = !sext_fits(imm, 20) || imm[0];
         end
         IMM_TYPE_W'(U_TYPE): begin
            instr = {imm[31:12], rd, opcode};
            err   = (imm[11:0] != '0);
         end
         IMM_TYPE_W'(R_TYPE): begin
            instr = {funct7, rs2, rs1, funct3, rd, opcode};
         end
         default: begin
            instr = '0;
            err   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_encode.sv
// Instruction encoder top: packer, two-entry skid buffer and saturating counters.
// in_ready depends only on registered state, never on out_ready.
module imm_encode
   import imm_pkg::*;
#(
   parameter int unsigned IMM_TYPE_W = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [IMM_TYPE_W-1:0] imm_type,
   input  logic [6:0]            opcode,
   input  logic [4:0]            rd,
   input  logic [4:0]            rs1,
   input  logic [4:0]            rs2,
   input  logic [2:0]            funct3,
   input  logic [6:0]            funct7,
   input  logic [31:0]           imm,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           instr,
   output logic                  err,
   input  logic                  cnt_clr,
   output logic [CNT_W-1:0]      word_cnt,
   output logic [CNT_W-1:0]      err_cnt
);

   buf_state_t  state;
   logic [31:0] pk_instr;
   logic        pk_err;
   logic [31:0] skid_instr;
   logic        skid_err;
   logic        in_acc;
   logic        out_acc;

   instr_pack #(.IMM_TYPE_W(IMM_TYPE_W)) u_pack (
      .imm_type (imm_type),
      .opcode   (opcode),
      .rd       (rd),
      .rs1      (rs1),
      .rs2      (rs2),
      .funct3   (funct3),
      .funct7   (funct7),
      .imm      (imm),
      .instr    (pk_instr),
      .err      (pk_err)
   );

   assign in_acc  = in_valid & in_ready;
   assign out_acc = out_valid & out_ready;

   // instr/err are the head entry; the skid register only ever holds the younger word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         instr      <= '0;
         err        <= 1'b0;
         skid_instr <= '0;
         skid_err   <= 1'b0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_acc) begin
                  instr     <= pk_instr;
                  err       <= pk_err;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (in_acc && !out_ready) begin
                  skid_instr <= pk_instr;
                  skid_err   <= pk_err;
                  in_ready   <= 1'b0;
                  state      <= FULL;
               end else if (in_acc) begin
                  instr <= pk_instr;
                  err   <= pk_err;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (out_ready) begin
                  instr    <= skid_instr;
                  err      <= skid_err;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state     <= EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt <= '0;
         err_cnt  <= '0;
      end else if (cnt_clr) begin
         word_cnt <= '0;
         err_cnt  <= '0;
      end else if (out_acc) begin
         if (word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
         if (err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_imm_encode.sv
// Scoreboard bench for imm_encode: directed encodings, backpressure, counters, reset.
// A second instance with narrow counters exercises saturation.
module tb_imm_encode;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  imm_type = '0;
   logic [6:0]  opcode = '0;
   logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
   logic [2:0]  funct3 = '0;
   logic [6:0]  funct7 = '0;
   logic [31:0] imm = '0;
   logic        out_ready = 1'b0;
   logic        cnt_clr = 1'b0;

   logic        in_ready, out_valid, err;
   logic [31:0] instr;
   logic [15:0] word_cnt, err_cnt;
   logic        in_ready3, out_valid3, err3;
   logic [31:0] instr3;
   logic [2:0]  word_cnt3, err_cnt3;

   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;
   logic [32:0] q[$];

   always #5 clk = ~clk;

   imm_encode #(.IMM_TYPE_W(3), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .imm_type(imm_type), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .err(err),
      .cnt_clr(cnt_clr), .word_cnt(word_cnt), .err_cnt(err_cnt)
   );

   imm_encode #(.IMM_TYPE_W(3), .CNT_W(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
      .imm_type(imm_type), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .funct3(funct3), .funct7(funct7), .imm(imm),
      .out_valid(out_valid3), .out_ready(out_ready), .instr(instr3), .err(err3),
      .cnt_clr(cnt_clr), .word_cnt(word_cnt3), .err_cnt(err_cnt3)
   );

   typedef struct {
      logic [2:0]  t;
      logic [6:0]  op;
      logic [4:0]  d, s1, s2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] im;
      logic [31:0] ei;
      logic        ee;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send(input vec_t v, output int unsigned waits);
      waits = 0;
      imm_type = v.t; opcode = v.op; rd = v.d; rs1 = v.s1; rs2 = v.s2;
      funct3 = v.f3; funct7 = v.f7; imm = v.im; in_valid = 1'b1;
      while (!in_ready && waits < 20) begin
         @(posedge clk); #1;
         waits++;
      end
      if (!in_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
      end else begin
         chk("in_ready3", 32'(in_ready3), 32'd1);
         q.push_back({v.ee, v.ei});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic monitor_loop();
      logic [15:0] ewc = '0, eec = '0;
      logic [2:0]  ewc3 = '0, eec3 = '0;
      logic        stall_prev = 1'b0;
      logic [31:0] prev_instr = '0;
      logic        prev_err = 1'b0;
      logic [32:0] e;
      logic        hs;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            q.delete();
            ewc = '0; eec = '0; ewc3 = '0; eec3 = '0;
            stall_prev = 1'b0;
         end else begin
            hs = 1'b0;
            e  = '0;
            chk("word_cnt", 32'(word_cnt), 32'(ewc));
            chk("err_cnt", 32'(err_cnt), 32'(eec));
            chk("word_cnt3", 32'(word_cnt3), 32'(ewc3));
            chk("err_cnt3", 32'(err_cnt3), 32'(eec3));
            if (stall_prev) begin
               chk("hold_instr", instr, prev_instr);
               chk("hold_err", 32'(err), 32'(prev_err));
            end
            if (out_valid && out_ready) begin
               hs = 1'b1;
               if (q.size() == 0) begin
                  n_cmp++; n_fail++;
                  $display("FAIL unexpected_word: got %h expected no word", instr);
               end else begin
                  e = q.pop_front();
                  chk("instr", instr, e[31:0]);
                  chk("err", 32'(err), 32'(e[32]));
                  chk("instr3", instr3, e[31:0]);
                  chk("out_valid3", 32'(out_valid3), 32'd1);
               end
            end
            if (cnt_clr) begin
               ewc = '0; eec = '0; ewc3 = '0; eec3 = '0;
            end else if (hs) begin
               if (ewc != 16'hFFFF) ewc++;
               if (ewc3 != 3'h7) ewc3++;
               if (e[32] && eec != 16'hFFFF) eec++;
               if (e[32] && eec3 != 3'h7) eec3++;
            end
            stall_prev = out_valid && !out_ready;
            prev_instr = instr;
            prev_err   = err;
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_instr"}, instr, 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_word_cnt"}, 32'(word_cnt), 32'd0);
      chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
   endtask

   function automatic vec_t addi(input logic [4:0] d, input logic [31:0] ei);
      vec_t v;
      v = '{t:3'd0, op:7'h13, d:d, s1:5'd0, s2:5'd0, f3:3'd0, f7:7'd0, im:32'd5, ei:ei, ee:1'b0};
      return v;
   endfunction

   vec_t vecs[12];
   int unsigned w;

   initial begin
      vecs[0]  = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000005, 32'h00500093, 1'b0};
      vecs[1]  = '{3'd1, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'h00000008, 32'h00512423, 1'b0};
      vecs[2]  = '{3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
      vecs[3]  = '{3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h001000EF, 1'b0};
      vecs[4]  = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h80000093, 1'b1};
      vecs[5]  = '{3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000006, 32'h00000363, 1'b0};
      vecs[6]  = '{3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000005, 32'h00000263, 1'b1};
      vecs[7]  = '{3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123451B7, 1'b0};
      vecs[8]  = '{3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 32'h123451B7, 1'b1};
      vecs[9]  = '{3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF, 32'h002081B3, 1'b0};
      vecs[10] = '{3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 1'b0};
      vecs[11] = '{3'd6, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'h00000005, 32'h00000000, 1'b1};

      fork
         monitor_loop();
      join_none

      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Encodings at full throughput, with one-cycle latency on the first word.
      out_ready = 1'b1;
      send(vecs[0], w);
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("latency_instr", instr, 32'h00500093);
      for (int i = 1; i < 12; i++) send(vecs[i], w);
      repeat (3) @(posedge clk);
      #1;
      chk("total_words", 32'(word_cnt), 32'd12);
      chk("total_errs", 32'(err_cnt), 32'd4);
      chk("sat_words3", 32'(word_cnt3), 32'd7);
      chk("errs3", 32'(err_cnt3), 32'd4);

      // Backpressure: two words fill the buffer, the third waits.
      out_ready = 1'b0;
      send(addi(5'd2, 32'h00500113), w);
      send(addi(5'd3, 32'h00500193), w);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      imm_type = 3'd0; opcode = 7'h13; rd = 5'd4; rs1 = '0; imm = 32'd5; in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_head", instr, 32'h00500113);
      out_ready = 1'b1;
      send(addi(5'd4, 32'h00500213), w);
      chk("third_accept_wait", w, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("drained", 32'(q.size()), 32'd0);

      // Clear beats a same-cycle handshake.
      send(addi(5'd5, 32'h00500293), w);
      cnt_clr = 1'b1;
      @(posedge clk); #1;
      cnt_clr = 1'b0;
      chk("clr_words", 32'(word_cnt), 32'd0);
      chk("clr_errs", 32'(err_cnt), 32'd0);
      send(vecs[4], w);
      repeat (2) @(posedge clk);
      #1;
      chk("post_clr_words", 32'(word_cnt), 32'd1);
      chk("post_clr_errs", 32'(err_cnt), 32'd1);

      // Reset while two words are buffered.
      out_ready = 1'b0;
      send(addi(5'd6, 32'h00500313), w);
      send(addi(5'd7, 32'h00500393), w);
      chk("pre_rst_full", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send('{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 32'h000012B7, 1'b0}, w);
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_words", 32'(word_cnt), 32'd1);
      chk("final_drain", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog");
   end

endmodule
